clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Run-time controller for the team's toggle-style clock divider datapath. It owns the half-period count and the divided output. It accepts divide-ratio change requests over a valid/ready handshake, and applies them only at a full-period boundary so the output never glitches. It gates the divided output on and off cleanly, always stopping with the output low. It sits between the configuration/CSR logic and the blocks that consume the divided frequency and tick.

Parameters:
CNT_W, 32, width of half-period register and internal counter
DEFAULT_HALF, 2, half-period (in i_clk cycles) loaded at reset; must be >= 1

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_enable  input  1  level; 1 = run divider, 0 = drain and stop
i_req_valid  input  1  new half-period request valid
i_req_half  input  CNT_W  requested half-period in i_clk cycles
o_req_ready  output  1  request can be accepted this cycle
o_err  output  1  one-cycle pulse: accepted request had i_req_half == 0, so it was discarded
o_frequency  output  1  divided clock output (registered)
o_tick  output  1  one-cycle pulse on every o_frequency toggle
o_busy  output  1  1 in every state except IDLE

Behaviour:
- Reset (async, i_reset_n=0) values:
  - state=IDLE, half=DEFAULT_HALF, pend=0, cnt=0.
  - o_frequency=0, o_tick=0, o_err=0, o_busy=0, o_req_ready=1.
- Handshake:
  - Transfer occurs when i_req_valid & o_req_ready at a rising edge.
  - o_req_ready=1 in IDLE and RUN; 0 in PENDING and DRAIN.
  - i_req_half==0 is accepted but discarded: o_err=1 on the next cycle, no state or register change.
- IDLE:
  - o_frequency=0, cnt held at 0.
  - An accepted legal request loads half directly at that edge.
  - i_enable=1 -> RUN next cycle.
  - If a request and an enable rise arrive in the same cycle, the new half is used for the first period.
- RUN / PENDING counting:
  - cnt increments each cycle.
  - When cnt == half-1: o_frequency inverts, o_tick=1, cnt=0 (all registered, same edge).
  - Result: output period = 2*half cycles, and the first toggle occurs half cycles after entering RUN.
  - half=1 gives o_frequency = i_clk/2 with o_tick high continuously.
- RUN: an accepted legal request stores pend and moves to PENDING.
- PENDING:
  - At the toggle where o_frequency goes 1->0: half<=pend, cnt<=0, -> RUN.
  - Toggles 0->1 do not apply pend.
- Enable drop in RUN or PENDING:
  - If o_frequency==0: -> IDLE next cycle, cnt<=0.
  - Else: -> DRAIN, keep counting until the 1->0 toggle (o_tick pulses), then -> IDLE.
  - A pending value is loaded into half on the transition into IDLE.
- DRAIN: i_enable re-asserted -> the drain still completes to IDLE, then re-enters RUN on the following cycle if i_enable is still 1.
- Arithmetic:
  - cnt is CNT_W bits, compared for equality only, with no wrap-around beyond half-1.
  - half is never 0 by construction.
- Reset mid-operation: immediate return to reset values; pending request lost.
- Latency:
  - Request in IDLE: 1 cycle to take effect.
  - Request in RUN: effective at the next 1->0 toggle, i.e. at most 2*half_old cycles.

Optional Feature:
- Macro: CLK_DIV_CTRL_PERIOD_CNT_EN.
- Defined:
  - Adds output o_period_cnt [15:0], reset 0.
  - Increments on each 1->0 toggle of o_frequency, wraps 0xFFFF->0.
  - Cleared to 0 when entering RUN from IDLE.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset release, half=2 default, i_enable=1 -> o_frequency toggles every 2 cycles (period 4); o_tick high on each toggle edge; o_busy=1.
2. In IDLE, request half=5, then enable -> first toggle 5 cycles after RUN entry; period 10; o_req_ready stays 1.
3. In RUN (half=3, o_frequency=1 mid half-period), request half=1 -> o_req_ready=0 until the next 1->0 toggle; afterwards o_frequency = i_clk/2 with no shortened high phase.
4. Request half=0 in RUN -> o_err pulses exactly 1 cycle; period unchanged; no PENDING entry.
5. Drop i_enable while o_frequency=1 (half=4) -> DRAIN, output stays high until its 4th count, falls with o_tick, then IDLE with o_busy=0. Repeat with o_frequency=0 -> IDLE the next cycle.
6. Assert i_reset_n=0 during PENDING -> all outputs at reset values immediately; after release, half=DEFAULT_HALF (pending discarded). With CLK_DIV_CTRL_PERIOD_CNT_EN, o_period_cnt=0.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl - run-time controller for the toggle-style clock divider.
//
// Owns the half-period count and the divided output. New half-period values
// arrive over a valid/ready handshake and are applied only when the output
// falls 1->0, so a period is never shortened or stretched mid-phase. The
// output is gated on/off cleanly and always parks low.
//
// Optional feature macro: CLK_DIV_CTRL_PERIOD_CNT_EN
//   Adds o_period_cnt[15:0], counting 1->0 output toggles. It is cleared on
//   IDLE->RUN and wraps.
//
// Ports:
//   i_clk        system clock (rising edge)
//   i_reset_n    async active-low reset
//   i_enable     1 = run, 0 = drain to low and stop
//   i_req_valid  half-period request valid
//   i_req_half   requested half-period (i_clk cycles)
//   o_req_ready  request accepted this cycle if valid (IDLE/RUN)
//   o_err        1-cycle pulse: accepted request was 0 and was discarded
//   o_frequency  divided clock (registered)
//   o_tick       1-cycle pulse on every o_frequency toggle
//   o_busy       1 whenever not IDLE
module clk_div_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DEFAULT_HALF = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_req_valid,
  input  logic [CNT_W-1:0] i_req_half,
  output logic             o_req_ready,
  output logic             o_err,
  output logic             o_frequency,
  output logic             o_tick,
  output logic             o_busy
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]      o_period_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PENDING, DRAIN} state_t;

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] half, pend, cnt;
  logic             pend_vld;

  logic req_ok, req_zero, tog, fall;

  assign o_req_ready = (state == IDLE) || (state == RUN);
  assign o_busy      = (state != IDLE);

  assign req_ok   = i_req_valid & o_req_ready & (i_req_half != '0);
  assign req_zero = i_req_valid & o_req_ready & (i_req_half == '0);
  // End of the current half-period; equality only, cnt never passes half-1.
  assign tog      = (cnt == half - ONE);
  assign fall     = tog & o_frequency;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      half        <= HALF_RST;
      pend        <= '0;
      pend_vld    <= 1'b0;
      cnt         <= '0;
      o_frequency <= 1'b0;
      o_tick      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_tick <= 1'b0;
      o_err  <= req_zero;
      case (state)
        IDLE: begin
          cnt         <= '0;
          o_frequency <= 1'b0;
          // Loaded at the same edge RUN is entered, so a request arriving
          // together with enable shapes the very first period.
          if (req_ok)   half  <= i_req_half;
          if (i_enable) state <= RUN;
        end

        RUN, PENDING: begin
          if (!i_enable && !o_frequency) begin
            // Already low: stop without finishing the low phase.
            state    <= IDLE;
            cnt      <= '0;
            pend_vld <= 1'b0;
            if (req_ok)        half <= i_req_half;
            else if (pend_vld) half <= pend;
          end else begin
            if (tog) begin
              o_frequency <= ~o_frequency;
              o_tick      <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + ONE;
            end

            if (!i_enable) begin
              // Output is high: keep counting until it falls.
              if (tog) begin
                state    <= IDLE;
                pend_vld <= 1'b0;
                if (req_ok)        half <= i_req_half;
                else if (pend_vld) half <= pend;
              end else begin
                state <= DRAIN;
                if (req_ok) begin
                  pend     <= i_req_half;
                  pend_vld <= 1'b1;
                end
              end
            end else if (state == PENDING) begin
              if (fall) begin
                half     <= pend;
                pend_vld <= 1'b0;
                state    <= RUN;
              end
            end else if (req_ok) begin
              pend     <= i_req_half;
              pend_vld <= 1'b1;
              state    <= PENDING;
            end
          end
        end

        DRAIN: begin
          // o_frequency is 1 throughout DRAIN, so every toggle here is 1->0.
          if (tog) begin
            o_frequency <= 1'b0;
            o_tick      <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
            pend_vld    <= 1'b0;
            if (pend_vld) half <= pend;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  // o_frequency is 0 in IDLE, so fall can only fire while running/draining.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                      o_period_cnt <= '0;
    else if (fall)                       o_period_cnt <= o_period_cnt + 16'd1;
    else if (state == IDLE && i_enable)  o_period_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_req_valid = 1'b0;
  logic [31:0] i_req_half = '0;
  logic        o_req_ready, o_err, o_frequency, o_tick, o_busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] o_period_cnt;
`endif

  clk_div_ctrl #(.CNT_W(32), .DEFAULT_HALF(2)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_enable    (i_enable),
    .i_req_valid (i_req_valid),
    .i_req_half  (i_req_half),
    .o_req_ready (o_req_ready),
    .o_err       (o_err),
    .o_frequency (o_frequency),
    .o_tick      (o_tick),
    .o_busy      (o_busy)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    .o_period_cnt(o_period_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic f;
  } tick_t;

  tick_t tq[$];
  int    eq[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait until the given edge count has passed, landing 1 time unit after it.
  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic push_tick(input int c, input logic f);
    tick_t t;
    t.c = c;
    t.f = f;
    tq.push_back(t);
  endtask

  // Monitor: every tick/err pulse must match the next expected event.
  always @(negedge i_clk) begin
    tick_t t;
    if (o_tick) begin
      if (tq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
      end else begin
        t = tq.pop_front();
        chk("tick_cycle", cyc, t.c);
        chk("tick_freq", {31'd0, o_frequency}, {31'd0, t.f});
      end
    end
    if (o_err) begin
      if (eq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_err: got err at cycle %0d expected none", cyc);
      end else begin
        chk("err_cycle", cyc, eq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, c3, c4;
    // Reset values
    #1;
    chk("rst_freq",  {31'd0, o_frequency}, 32'd0);
    chk("rst_tick",  {31'd0, o_tick},      32'd0);
    chk("rst_err",   {31'd0, o_err},       32'd0);
    chk("rst_busy",  {31'd0, o_busy},      32'd0);
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
    step_to(2);
    i_reset_n = 1'b1;

    // 1: default half=2 -> period 4
    step_to(4);
    c0 = cyc;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    chk("pcnt_rst", {16'd0, o_period_cnt}, 32'd0);
`endif
    i_enable = 1'b1;
    push_tick(c0 + 3, 1'b1); push_tick(c0 + 5, 1'b0);
    push_tick(c0 + 7, 1'b1); push_tick(c0 + 9, 1'b0);
    step_to(c0 + 1);
    chk("t1_busy", {31'd0, o_busy}, 32'd1);
    step_to(c0 + 9);
    chk("t1_freq_low", {31'd0, o_frequency}, 32'd0);
    i_enable = 1'b0;                         // drop while low -> IDLE next
    step_to(c0 + 10);
    chk("t1_idle_busy", {31'd0, o_busy}, 32'd0);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    chk("pcnt_t1", {16'd0, o_period_cnt}, 32'd2);
`endif

    // 2: request half=5 together with enable
    c1 = cyc;
    chk("t2_ready", {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1; i_req_half = 32'd5; i_enable = 1'b1;
    push_tick(c1 + 6, 1'b1); push_tick(c1 + 11, 1'b0);
    step_to(c1 + 1);
    i_req_valid = 1'b0;
    chk("t2_ready_run", {31'd0, o_req_ready}, 32'd1);
    step_to(c1 + 6);
    chk("t2_freq_high", {31'd0, o_frequency}, 32'd1);
    i_req_valid = 1'b1; i_req_half = 32'd3;  // moves to half=3 at next fall
    step_to(c1 + 7);
    i_req_valid = 1'b0;
    chk("t2_pending_ready", {31'd0, o_req_ready}, 32'd0);

    // 3: half=3, request half=1 mid high phase
    c2 = c1 + 11;
    step_to(c2);
    chk("t3_ready", {31'd0, o_req_ready}, 32'd1);
    push_tick(c2 + 3, 1'b1); push_tick(c2 + 6, 1'b0);
    for (int k = 7; k <= 13; k++) push_tick(c2 + k, logic'(k % 2));
    push_tick(c2 + 14, 1'b0);
    step_to(c2 + 4);
    i_req_valid = 1'b1; i_req_half = 32'd1;
    step_to(c2 + 5);
    i_req_valid = 1'b0;
    chk("t3_ready_low", {31'd0, o_req_ready}, 32'd0);
    chk("t3_freq_high", {31'd0, o_frequency}, 32'd1);
    step_to(c2 + 6);
    chk("t3_ready_back", {31'd0, o_req_ready}, 32'd1);

    // 4: zero request -> err pulse, no PENDING
    step_to(c2 + 10);
    chk("t4_freq", {31'd0, o_frequency}, 32'd0);
    i_req_valid = 1'b1; i_req_half = 32'd0;
    eq.push_back(c2 + 11);
    step_to(c2 + 11);
    i_req_valid = 1'b0;
    chk("t4_no_pending", {31'd0, o_req_ready}, 32'd1);

    // 5: move to half=4, then drain while high
    step_to(c2 + 12);
    i_req_valid = 1'b1; i_req_half = 32'd4;
    step_to(c2 + 13);
    i_req_valid = 1'b0;
    chk("t5_pending", {31'd0, o_req_ready}, 32'd0);
    c3 = c2 + 14;
    push_tick(c3 + 4, 1'b1); push_tick(c3 + 8, 1'b0); push_tick(c3 + 13, 1'b1);
    step_to(c3);
    chk("t5_ready", {31'd0, o_req_ready}, 32'd1);
    step_to(c3 + 5);
    chk("t5_freq_high", {31'd0, o_frequency}, 32'd1);
    i_enable = 1'b0;
    step_to(c3 + 6);
    chk("t5_drain_busy", {31'd0, o_busy}, 32'd1);
    chk("t5_drain_ready", {31'd0, o_req_ready}, 32'd0);
    step_to(c3 + 7);
    chk("t5_drain_high", {31'd0, o_frequency}, 32'd1);
    i_enable = 1'b1;                         // re-enable during drain
    step_to(c3 + 8);
    chk("t5_drained_low", {31'd0, o_frequency}, 32'd0);
    chk("t5_idle_busy", {31'd0, o_busy}, 32'd0);
    step_to(c3 + 9);
    chk("t5_rerun_busy", {31'd0, o_busy}, 32'd1);

    // 6: reset during PENDING
    step_to(c3 + 13);
    i_req_valid = 1'b1; i_req_half = 32'd7;
    step_to(c3 + 14);
    i_req_valid = 1'b0;
    chk("t6_pending", {31'd0, o_req_ready}, 32'd0);
    step_to(c3 + 15);
    chk("t6_freq_pre", {31'd0, o_frequency}, 32'd1);
    i_reset_n = 1'b0;
    #1;
    chk("t6_rst_freq",  {31'd0, o_frequency}, 32'd0);
    chk("t6_rst_busy",  {31'd0, o_busy},      32'd0);
    chk("t6_rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("t6_rst_tick",  {31'd0, o_tick},      32'd0);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    chk("t6_rst_pcnt", {16'd0, o_period_cnt}, 32'd0);
`endif
    i_enable = 1'b0;
    step_to(c3 + 16);
    i_reset_n = 1'b1;
    c4 = c3 + 17;
    step_to(c4);
    i_enable = 1'b1;                         // default half=2 again
    push_tick(c4 + 3, 1'b1); push_tick(c4 + 5, 1'b0);
    step_to(c4 + 5);
    i_enable = 1'b0;
    step_to(c4 + 10);
    chk("t6_end_busy", {31'd0, o_busy}, 32'd0);
    chk("ticks_left", tq.size(), 32'd0);
    chk("errs_left", eq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
